data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Multi-cycle data-memory controller placed directly downstream of the single-cycle core's ALU/decoder. It replaces the ideal one-cycle Data_Memory path. It takes the core's MemRead/MemWrite, ALU address and RT store data, performs byte/half/word lane alignment, and runs a req/ack handshake to a variable-latency memory. While the access is in flight it stalls the core (PC hold), then returns extended load data to the write-back mux.

Parameters:
TIMEOUT_CYC, 255, cycles in ACCESS without mem_ack_i before the access is aborted (1..255, 8-bit counter)
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
MemRead_i  in  1  load request from decoder
MemWrite_i  in  1  store request from decoder
size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend
addr_i  in  ADDR_W  byte address (ALU result)
wdata_i  in  32  store data (RT), value in low bits
rdata_o  out  32  aligned/extended load data to write-back mux
stall_o  out  1  core must hold PC and all state this cycle
misalign_o  out  1  current request is misaligned and was suppressed
timeout_o  out  1  sticky: an access timed out since reset
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  out  32  lane-replicated store data
mem_be_o  out  4  byte enables, little-endian lanes
mem_ack_i  in  1  memory completion, valid only while mem_req_o=1
mem_rdata_i  in  32  read word, valid with mem_ack_i

Behaviour:
- Reset (async, rst_i=0): state IDLE; all outputs 0; internal counter, latches and timeout_o cleared. Reset mid-access drops mem_req_o immediately; the in-flight transaction is abandoned.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Valid request (MemRead_i|MemWrite_i, aligned): stall_o=1 combinationally. On the clock edge, latch we, word address, be, wdata, byte offset, size and unsigned; go to ACCESS.
  - No request: stall_o=0, no state change.
- ACCESS: mem_req_o=1 with mem_we_o/addr/wdata/be registered and stable; stall_o=1; counter increments each cycle.
  - mem_ack_i=1: capture extended load data (0 for writes) into the rdata register; go to DONE. Ack on the first ACCESS cycle is legal.
  - Counter reaches TIMEOUT_CYC without ack: drop mem_req_o, set timeout_o (sticky), rdata register=0, go to DONE.
- DONE: stall_o=0; rdata_o valid; the core commits and advances PC on this edge; next state IDLE unconditionally. The same instruction is never re-issued.
- Minimum load/store instruction time = 3 cycles (IDLE detect, ACCESS+ack, DONE).
- rdata_o: equals the rdata register in DONE, 0 otherwise.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
- Misaligned request in IDLE: misalign_o=1 combinationally; stall_o=0; no memory request; store suppressed; rdata_o=0. The core proceeds.
- Store lanes: byte: be=1<<addr[1:0], wdata={4{wdata_i[7:0]}}. Half: be=addr[1]?1100:0011, wdata={2{wdata_i[15:0]}}. Word: be=1111, wdata=wdata_i.
- Load extraction: select the byte/half at the latched offset from mem_rdata_i, then sign- or zero-extend per unsigned_i. Word loads are passed through.
- MemRead_i and MemWrite_i both high: treated as a write; rdata=0.
- mem_ack_i outside ACCESS is ignored.
- Request inputs changing during ACCESS/DONE are ignored; the latched values rule.

Decomposition:
- Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum {IDLE, ACCESS, DONE}, byte-enable constants, timeout counter width.
- Sub-module dmem_lane_align (combinational): store replicate/be generation, load extract/extend, misalign detect. The FSM and handshake stay in the top.

Test Plan:
- Word load addr=0x10, mem_rdata=0xDEADBEEF, ack on 1st ACCESS cycle -> stall_o high 2 cycles, DONE rdata_o=0xDEADBEEF, mem_addr_o=0x10, be=1111.
- Byte store addr=0x13, wdata=0x000000A5 -> mem_we_o=1, be=1000, mem_wdata=0xA5A5A5A5, mem_addr_o=0x10.
- Signed half load addr=0x22, mem_rdata=0x8001_1234 -> rdata_o=0xFFFF8001; same with unsigned_i=1 -> 0x00008001.
- Word load addr=0x06 -> misalign_o=1, stall_o=0, mem_req_o never asserted, rdata_o=0.
- No ack, TIMEOUT_CYC=4 -> mem_req_o high 4 cycles then low, timeout_o=1 sticky, DONE rdata_o=0, stall releases.
- rst_i low during ACCESS with ack pending -> mem_req_o/stall_o fall asynchronously, state IDLE, a later ack is ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared encodings for the multi-cycle data-memory controller:
//                access sizes, FSM states, byte-enable patterns, counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_B0      = 4'b0001;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_if
//  Description : Request/acknowledge bus between the controller (master) and
//                the variable-latency data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [3:0]        mem_be_o;
   logic              mem_ack_i;
   logic [31:0]       mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Purely combinational lane logic: store byte-enables and data
//                replication, misalignment detection, load extract/extend.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   output logic        misalign,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: enables and replicated data from size and byte offset;
   // the reserved size code behaves as a word access.
   always_comb begin
      st_be        = BE_WORD;
      st_wdata_rep = st_wdata;
      misalign     = 1'b0;
      case (st_size)
         SZ_BYTE: begin
            st_be        = BE_B0 << st_off;
            st_wdata_rep = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_be        = st_off[1] ? BE_HI_HALF : BE_LO_HALF;
            st_wdata_rep = {2{st_wdata[15:0]}};
            misalign     = st_off[0];
         end
         default: begin
            misalign     = |st_off;
         end
      endcase
   end

   // Load side: pick the addressed lane, then sign- or zero-extend.
   always_comb begin
      byte_sel = ld_word[7:0];
      case (ld_off)
         2'd1:    byte_sel = ld_word[15:8];
         2'd2:    byte_sel = ld_word[23:16];
         2'd3:    byte_sel = ld_word[31:24];
         default: byte_sel = ld_word[7:0];
      endcase
      half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_size)
         SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: ld_data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
         default: ld_data = ld_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Multi-cycle data-memory controller. Latches a core load/store,
//                runs a req/ack handshake with timeout, stalls the core while
//                in flight and returns extended load data in the DONE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int ADDR_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic              timeout_o,
   dmem_if.master            mem
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              we_r, uns_r, timeout_r;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        be_r;
   logic [31:0]       wdata_r, rdata_r;
   logic [1:0]        off_r, size_r;

   logic              stall, misal, latch_en, done_ack, done_to;
   logic [3:0]        st_be;
   logic [31:0]       st_wdata_rep, ld_data;
   logic              misalign_w;

   dmem_lane_align u_align (
      .st_size      (size_i),
      .st_off       (addr_i[1:0]),
      .st_wdata     (wdata_i),
      .st_be        (st_be),
      .st_wdata_rep (st_wdata_rep),
      .misalign     (misalign_w),
      .ld_size      (size_r),
      .ld_off       (off_r),
      .ld_unsigned  (uns_r),
      .ld_word      (mem.mem_rdata_i),
      .ld_data      (ld_data)
   );

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and core-facing control; misaligned requests never leave IDLE.
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      misal    = 1'b0;
      latch_en = 1'b0;
      done_ack = 1'b0;
      done_to  = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead_i | MemWrite_i) begin
               if (misalign_w) begin
                  misal = 1'b1;
               end else begin
                  stall    = 1'b1;
                  latch_en = 1'b1;
                  state_nx = ACCESS;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (mem.mem_ack_i) begin
               done_ack = 1'b1;
               state_nx = DONE;
            end else if (cnt == TO_LAST) begin
               done_to  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latches, wait counter, result register and sticky timeout flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt       <= '0;
         we_r      <= 1'b0;
         uns_r     <= 1'b0;
         addr_r    <= '0;
         be_r      <= '0;
         wdata_r   <= '0;
         off_r     <= '0;
         size_r    <= '0;
         rdata_r   <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (latch_en) begin
            cnt     <= '0;
            we_r    <= MemWrite_i;
            uns_r   <= unsigned_i;
            addr_r  <= {addr_i[ADDR_W-1:2], 2'b00};
            be_r    <= st_be;
            wdata_r <= st_wdata_rep;
            off_r   <= addr_i[1:0];
            size_r  <= size_i;
         end else if (state == ACCESS) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (done_ack) rdata_r <= we_r ? '0 : ld_data;
         if (done_to) begin
            rdata_r   <= '0;
            timeout_r <= 1'b1;
         end
      end
   end

   // Combinational core outputs are forced low while reset is asserted.
   assign stall_o     = rst_i & stall;
   assign misalign_o  = rst_i & misal;
   assign timeout_o   = timeout_r;
   assign rdata_o     = (state == DONE) ? rdata_r : '0;

   assign mem.mem_req_o   = (state == ACCESS);
   assign mem.mem_we_o    = (state == ACCESS) & we_r;
   assign mem.mem_be_o    = (state == ACCESS) ? be_r : BE_NONE;
   assign mem.mem_addr_o  = addr_r;
   assign mem.mem_wdata_o = wdata_r;

endmodule
`default_nettype wire
